// File: rtl/ysyx_24070016_lsu_if.sv
// Bundles the LSU's upstream, memory and write-back handshakes.
// The master modport is the environment side; the slave modport is the LSU.
interface ysyx_24070016_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_alu_result;
  logic [ADDR_W-1:0] in_store_data;
  logic [1:0]        in_mem_op;
  logic [1:0]        in_size;
  logic              in_unsigned;
  logic [4:0]        in_rd;
  logic              in_rd_wen;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_wen;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [ADDR_W-1:0] mem_req_wdata;
  logic [3:0]        mem_req_wmask;
  logic              mem_rsp_valid;
  logic [ADDR_W-1:0] mem_rsp_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_wb_data;
  logic [4:0]        out_rd;
  logic              out_rd_wen;
  logic              out_misalign;

  modport master (
    output in_valid, in_alu_result, in_store_data, in_mem_op, in_size,
           in_unsigned, in_rd, in_rd_wen,
    input  in_ready,
    input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  out_valid, out_wb_data, out_rd, out_rd_wen, out_misalign,
    output out_ready
  );

  modport slave (
    input  in_valid, in_alu_result, in_store_data, in_mem_op, in_size,
           in_unsigned, in_rd, in_rd_wen,
    output in_ready,
    output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output out_valid, out_wb_data, out_rd, out_rd_wen, out_misalign,
    input  out_ready
  );
endinterface

// File: rtl/ysyx_24070016_lsu.sv
// Load/store stage: one memory access per instruction, result handed to write-back.
// Define YSYX_24070016_LSU_MISALIGN_TRAP_EN to flag misaligned accesses instead of issuing them.
module ysyx_24070016_lsu #(
  parameter int ADDR_W = 32
) (
  input logic                clock,
  input logic                reset,
  ysyx_24070016_lsu_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            next_s;
  logic              in_ready_r;
  logic              req_valid_r;
  logic              out_valid_r;
  logic [ADDR_W-1:0] addr_r;
  logic              wen_r;
  logic [ADDR_W-1:0] wdata_r;
  logic [3:0]        wmask_r;
  logic [1:0]        size_r;
  logic              uns_r;
  logic [4:0]        rd_r;
  logic              rd_wen_r;
  logic [ADDR_W-1:0] wb_r;
  logic              out_rd_wen_r;
  logic              mis_r;

  logic              accept_s;
  logic              is_mem_s;
  logic              is_store_s;
  logic              trap_s;
  logic [1:0]        off_s;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] base;
    case (size)
      2'b00:   base = 4'b0001;
      2'b01:   base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << off;
  endfunction

  // Bytes shifted out of the top of the word are lost, so misaligned loads truncate.
  function automatic logic [ADDR_W-1:0] load_extract(input logic [ADDR_W-1:0] rdata,
                                                     input logic [1:0] off,
                                                     input logic [1:0] size,
                                                     input logic uns);
    logic [ADDR_W-1:0] r;
    logic [ADDR_W-1:0] res;
    r = rdata >> {off, 3'b000};
    case (size)
      2'b00:   res = uns ? {{(ADDR_W-8){1'b0}}, r[7:0]}   : {{(ADDR_W-8){r[7]}}, r[7:0]};
      2'b01:   res = uns ? {{(ADDR_W-16){1'b0}}, r[15:0]} : {{(ADDR_W-16){r[15]}}, r[15:0]};
      default: res = r;
    endcase
    return res;
  endfunction

  assign off_s      = bus.in_alu_result[1:0];
  assign is_store_s = (bus.in_mem_op == 2'b10);
  assign is_mem_s   = (bus.in_mem_op == 2'b01) || is_store_s;
  assign accept_s   = bus.in_valid && (state_r == IDLE);

`ifdef YSYX_24070016_LSU_MISALIGN_TRAP_EN
  assign trap_s = is_mem_s && (((bus.in_size == 2'b01) && off_s[0]) ||
                               (bus.in_size[1] && (off_s != 2'b00)));
`else
  assign trap_s = 1'b0;
`endif

  // Next-state selection; memory bus inputs only matter in their own states.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (is_mem_s && !trap_s) begin
            next_s = REQ;
          end else begin
            next_s = OUT;
          end
        end else begin
          next_s = IDLE;
        end
      end
      REQ: begin
        if (bus.mem_req_ready) begin
          next_s = WAIT;
        end else begin
          next_s = REQ;
        end
      end
      WAIT: begin
        if (bus.mem_rsp_valid) begin
          next_s = OUT;
        end else begin
          next_s = WAIT;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          next_s = IDLE;
        end else begin
          next_s = OUT;
        end
      end
      default: next_s = IDLE;
    endcase
  end

  // State, registered handshake flags, captured instruction and write-back result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      in_ready_r   <= 1'b1;
      req_valid_r  <= 1'b0;
      out_valid_r  <= 1'b0;
      addr_r       <= '0;
      wen_r        <= 1'b0;
      wdata_r      <= '0;
      wmask_r      <= 4'b0000;
      size_r       <= 2'b00;
      uns_r        <= 1'b0;
      rd_r         <= 5'd0;
      rd_wen_r     <= 1'b0;
      wb_r         <= '0;
      out_rd_wen_r <= 1'b0;
      mis_r        <= 1'b0;
    end else begin
      state_r     <= next_s;
      in_ready_r  <= (next_s == IDLE);
      req_valid_r <= (next_s == REQ);
      out_valid_r <= (next_s == OUT);
      if (accept_s) begin
        addr_r       <= bus.in_alu_result;
        wen_r        <= is_store_s;
        wdata_r      <= bus.in_store_data << {off_s, 3'b000};
        wmask_r      <= is_store_s ? lane_mask(bus.in_size, off_s) : 4'b0000;
        size_r       <= bus.in_size;
        uns_r        <= bus.in_unsigned;
        rd_r         <= bus.in_rd;
        rd_wen_r     <= bus.in_rd_wen;
        // Memory ops overwrite these on the response; traps keep the address.
        wb_r         <= bus.in_alu_result;
        out_rd_wen_r <= is_mem_s ? 1'b0 : bus.in_rd_wen;
        mis_r        <= trap_s;
      end else if ((state_r == WAIT) && bus.mem_rsp_valid) begin
        wb_r         <= wen_r ? '0 : load_extract(bus.mem_rsp_rdata, addr_r[1:0], size_r, uns_r);
        out_rd_wen_r <= wen_r ? 1'b0 : rd_wen_r;
      end
    end
  end

  assign bus.in_ready      = in_ready_r;
  assign bus.mem_req_valid = req_valid_r;
  assign bus.mem_req_wen   = wen_r;
  assign bus.mem_req_addr  = addr_r;
  assign bus.mem_req_wdata = wdata_r;
  assign bus.mem_req_wmask = wmask_r;
  assign bus.out_valid     = out_valid_r;
  assign bus.out_wb_data   = wb_r;
  assign bus.out_rd        = rd_r;
  assign bus.out_rd_wen    = out_rd_wen_r;
  assign bus.out_misalign  = mis_r;
endmodule

// File: tb/tb_ysyx_24070016_lsu.sv
// Scoreboard bench for ysyx_24070016_lsu: expected requests/results queued at drive time.
module tb_ysyx_24070016_lsu;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ysyx_24070016_lsu_if bus ();
  ysyx_24070016_lsu dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  typedef struct {
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        mis;
  } exp_t;

  req_t req_q[$];
  exp_t exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit m_mis(input logic [1:0] size, input logic [1:0] off);
    return ((size == 2'b01) && off[0]) || (size[1] && (off != 2'b00));
  endfunction

  function automatic logic [3:0] m_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m = 4'b0000;
    for (int i = 0; i < nbytes(size); i++)
      if (int'(off) + i < 4) m[int'(off) + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] sd, input logic [1:0] off);
    logic [31:0] w = 32'h0;
    for (int lane = int'(off); lane < 4; lane++) w[8*lane +: 8] = sd[8*(lane - int'(off)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] off,
                                         input logic [1:0] size, input logic uns);
    logic [31:0] r = 32'h0;
    logic sgn;
    int n = nbytes(size);
    for (int i = 0; i < n; i++)
      if (int'(off) + i < 4) r[8*i +: 8] = rd[8*(int'(off) + i) +: 8];
    sgn = r[8*n - 1];
    for (int i = n; i < 4; i++) r[8*i +: 8] = (uns || !sgn) ? 8'h00 : 8'hFF;
    return r;
  endfunction

  // Drives one instruction from a negedge and follows it to its write-back handshake.
  task automatic run_instr(input string name, input logic [31:0] alu, input logic [31:0] sdata,
                           input logic [1:0] op, input logic [1:0] size, input logic uns,
                           input logic [4:0] rd, input logic wen, input logic [31:0] rdata,
                           input int req_delay, input int rsp_delay, input int out_delay,
                           input bit exp_mem, input logic [31:0] exp_wdata,
                           input logic [3:0] exp_wmask, input logic [31:0] exp_wb,
                           input logic exp_rd_wen, input logic exp_mis, input bit chk_lat);
    req_t rq;
    exp_t ex;
    int waited;
    check({name, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.in_alu_result = alu; bus.in_store_data = sdata;
    bus.in_mem_op = op; bus.in_size = size; bus.in_unsigned = uns;
    bus.in_rd = rd; bus.in_rd_wen = wen;
    ex.wb = exp_wb; ex.rd = rd; ex.rd_wen = exp_rd_wen; ex.mis = exp_mis;
    exp_q.push_back(ex);
    if (exp_mem) begin
      rq.addr = alu; rq.wen = (op == 2'b10); rq.wdata = exp_wdata; rq.wmask = exp_wmask;
      req_q.push_back(rq);
    end
    @(negedge clock);
    bus.in_valid = 1'b0;
    if (exp_mem) begin
      waited = 0;
      while (!bus.mem_req_valid && waited < 20) begin @(negedge clock); waited++; end
      check({name, ".req_valid"}, 32'(bus.mem_req_valid), 32'd1);
      if (chk_lat) check({name, ".req_lat"}, 32'(waited), 32'd0);
      rq = req_q.pop_front();
      if (bus.mem_req_valid) begin
        for (int i = 0; i <= req_delay; i++) begin
          check({name, ".req_addr"}, bus.mem_req_addr, rq.addr);
          check({name, ".req_wen"}, 32'(bus.mem_req_wen), 32'(rq.wen));
          check({name, ".req_wmask"}, 32'(bus.mem_req_wmask), 32'(rq.wmask));
          if (rq.wen) check({name, ".req_wdata"}, bus.mem_req_wdata, rq.wdata);
          check({name, ".req_in_ready"}, 32'(bus.in_ready), 32'd0);
          if (i < req_delay) @(negedge clock);
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clock);
        bus.mem_req_ready = 1'b0;
        check({name, ".wait_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
        for (int i = 0; i < rsp_delay; i++) begin
          check({name, ".wait_out_valid"}, 32'(bus.out_valid), 32'd0);
          @(negedge clock);
        end
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = rdata;
        @(negedge clock);
        bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = 32'h0;
      end
    end
    waited = 0;
    while (!bus.out_valid && waited < 20) begin @(negedge clock); waited++; end
    check({name, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    if (chk_lat) check({name, ".out_lat"}, 32'(waited), 32'd0);
    ex = exp_q.pop_front();
    if (bus.out_valid) begin
      for (int i = 0; i <= out_delay; i++) begin
        check({name, ".wb_data"}, bus.out_wb_data, ex.wb);
        check({name, ".rd"}, 32'(bus.out_rd), 32'(ex.rd));
        check({name, ".rd_wen"}, 32'(bus.out_rd_wen), 32'(ex.rd_wen));
        check({name, ".misalign"}, 32'(bus.out_misalign), 32'(ex.mis));
        check({name, ".out_in_ready"}, 32'(bus.in_ready), 32'd0);
        if (!exp_mem) check({name, ".no_req"}, 32'(bus.mem_req_valid), 32'd0);
        if (i < out_delay) @(negedge clock);
      end
      bus.out_ready = 1'b1;
      @(negedge clock);
      bus.out_ready = 1'b0;
      check({name, ".out_drop"}, 32'(bus.out_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic [1:0]  r_op, r_size;
    logic [31:0] r_addr, r_sd, r_rd;
    logic        r_uns, r_wen, r_trap;
    logic [4:0]  r_dst;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_alu_result = 32'h0; bus.in_store_data = 32'h0;
    bus.in_mem_op = 2'b00; bus.in_size = 2'b00; bus.in_unsigned = 1'b0;
    bus.in_rd = 5'd0; bus.in_rd_wen = 1'b0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = 32'h0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);
    check("rst.req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("rst.req_wmask", 32'(bus.mem_req_wmask), 32'd0);
    check("rst.req_addr", bus.mem_req_addr, 32'h0);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.wb_data", bus.out_wb_data, 32'h0);
    check("rst.misalign", 32'(bus.out_misalign), 32'd0);
    reset = 1'b0;

    run_instr("alu", 32'h1234_5678, 32'h0, 2'b00, 2'b10, 1'b0, 5'd5, 1'b1, 32'h0, 0, 0, 0,
              1'b0, 32'h0, 4'h0, 32'h1234_5678, 1'b1, 1'b0, 1'b1);
    run_instr("lb", 32'h8000_0003, 32'h0, 2'b01, 2'b00, 1'b0, 5'd6, 1'b1, 32'h80FF_0000, 0, 0, 0,
              1'b1, 32'h0, 4'h0, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b1);
    run_instr("lbu", 32'h8000_0003, 32'h0, 2'b01, 2'b00, 1'b1, 5'd7, 1'b1, 32'h80FF_0000, 0, 0, 0,
              1'b1, 32'h0, 4'h0, 32'h0000_0080, 1'b1, 1'b0, 1'b1);
    run_instr("sh", 32'h8000_0002, 32'h0000_ABCD, 2'b10, 2'b01, 1'b0, 5'd8, 1'b1, 32'h0, 3, 0, 0,
              1'b1, 32'hABCD_0000, 4'b1100, 32'h0, 1'b0, 1'b0, 1'b0);
    run_instr("lw_slow", 32'h1000_0000, 32'h0, 2'b01, 2'b10, 1'b0, 5'd9, 1'b1, 32'h0BAD_F00D, 0, 4, 2,
              1'b1, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0);
    run_instr("alu_nowen", 32'h0000_0001, 32'h0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0, 32'h0, 0, 0, 0,
              1'b0, 32'h0, 4'h0, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    run_instr("lh", 32'h0000_2002, 32'h0, 2'b01, 2'b01, 1'b0, 5'd10, 1'b1, 32'h8001_7FFF, 1, 1, 1,
              1'b1, 32'h0, 4'h0, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0);
    run_instr("lhu", 32'h0000_2002, 32'h0, 2'b01, 2'b01, 1'b1, 5'd11, 1'b1, 32'h8001_7FFF, 0, 2, 0,
              1'b1, 32'h0, 4'h0, 32'h0000_8001, 1'b1, 1'b0, 1'b0);
    run_instr("sb", 32'h0000_0101, 32'h1234_56A5, 2'b10, 2'b00, 1'b0, 5'd12, 1'b1, 32'h0, 0, 0, 0,
              1'b1, 32'h3456_A500, 4'b0010, 32'h0, 1'b0, 1'b0, 1'b0);
    run_instr("op11", 32'hCAFE_F00D, 32'h0, 2'b11, 2'b00, 1'b0, 5'd31, 1'b1, 32'h0, 0, 0, 0,
              1'b0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1);
    run_instr("sw_sz11", 32'h0000_0040, 32'hDEAD_BEEF, 2'b10, 2'b11, 1'b0, 5'd13, 1'b1, 32'h0, 0, 0, 0,
              1'b1, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset while waiting for a response, then let the stale response arrive.
    bus.in_valid = 1'b1; bus.in_alu_result = 32'h8000_0010; bus.in_mem_op = 2'b01;
    bus.in_size = 2'b10; bus.in_rd = 5'd14; bus.in_rd_wen = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
    check("rstwait.req_valid", 32'(bus.mem_req_valid), 32'd1);
    bus.mem_req_ready = 1'b1;
    @(negedge clock);
    bus.mem_req_ready = 1'b0;
    check("rstwait.in_wait", 32'(bus.mem_req_valid), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rstwait.in_ready", 32'(bus.in_ready), 32'd1);
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'h1122_3344;
    @(negedge clock);
    bus.mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rstwait.out_valid", 32'(bus.out_valid), 32'd0);
      check("rstwait.idle_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clock);
    end

`ifdef YSYX_24070016_LSU_MISALIGN_TRAP_EN
    run_instr("lw_mis", 32'h8000_0001, 32'h0, 2'b01, 2'b10, 1'b0, 5'd15, 1'b1, 32'hDDCC_BBAA, 0, 0, 0,
              1'b0, 32'h0, 4'h0, 32'h8000_0001, 1'b0, 1'b1, 1'b1);
`else
    run_instr("lw_mis", 32'h8000_0001, 32'h0, 2'b01, 2'b10, 1'b0, 5'd15, 1'b1, 32'hDDCC_BBAA, 0, 0, 0,
              1'b1, 32'h0, 4'h0, 32'h00DD_CCBB, 1'b1, 1'b0, 1'b1);
`endif

    for (int k = 0; k < 16; k++) begin
      r_op = 2'($urandom_range(1, 2)); r_size = 2'($urandom_range(0, 3));
      r_addr = $urandom; r_sd = $urandom; r_rd = $urandom;
      r_uns = 1'($urandom_range(0, 1)); r_wen = 1'($urandom_range(0, 1));
      r_dst = 5'($urandom_range(0, 31));
`ifdef YSYX_24070016_LSU_MISALIGN_TRAP_EN
      r_trap = m_mis(r_size, r_addr[1:0]);
`else
      r_trap = 1'b0;
`endif
      if (r_trap)
        run_instr("rnd_trap", r_addr, r_sd, r_op, r_size, r_uns, r_dst, r_wen, r_rd, 0, 0, 0,
                  1'b0, 32'h0, 4'h0, r_addr, 1'b0, 1'b1, 1'b0);
      else
        run_instr("rnd", r_addr, r_sd, r_op, r_size, r_uns, r_dst, r_wen, r_rd,
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  1'b1, m_wdata(r_sd, r_addr[1:0]),
                  (r_op == 2'b10) ? m_mask(r_size, r_addr[1:0]) : 4'h0,
                  (r_op == 2'b10) ? 32'h0 : m_load(r_rd, r_addr[1:0], r_size, r_uns),
                  (r_op == 2'b10) ? 1'b0 : r_wen, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
